instr_packer: RTL and testbench
===============================

Name: instr_packer

Overview:
- Write-side counterpart of the BIP operand extension path: narrows a 16-bit operand to the 11-bit instruction operand field, range-checks it and packs it with a 5-bit opcode into a 16-bit instruction word.
- Writes packed words sequentially into program memory.
- Sits between the UART debug/loader front end and program memory; the core's extender later zero-extends the same field back to 16 bits.

Parameters:
- N_BUS, 16, instruction/data word width.
- N_BUS_IN, 11, operand field width. Opcode width is N_BUS-N_BUS_IN (5).
- N_ADDR, 11, program memory address width. Capacity is 2**N_ADDR words.
- HALT_OP, 5'b00000, opcode that terminates a program.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_clear  input  1  synchronous restart of a load: state, address and flags return to reset values.
- i_valid  input  1  opcode/operand pair presented.
- i_opcode  input  N_BUS-N_BUS_IN  instruction opcode.
- i_operand  input  N_BUS  operand to narrow.
- o_ready  output  1  block can accept a pair this cycle.
- o_mem_we  output  1  program memory write strobe, one cycle per word.
- o_mem_addr  output  N_ADDR  write address.
- o_mem_data  output  N_BUS  packed word: {opcode, operand[N_BUS_IN-1:0]}.
- o_count  output  N_ADDR+1  number of words written.
- o_err  output  1  sticky flag: at least one operand was rejected.
- o_done  output  1  HALT word written.
- o_full  output  1  memory filled without a HALT.

Behaviour:
- Reset (async, i_reset=1): state IDLE; o_ready=1; o_mem_we=0; o_mem_addr=0; o_mem_data=0; o_count=0; o_err=0; o_done=0; o_full=0. o_mem_we drops immediately, including mid-write.
- States:
  - IDLE: o_ready=1.
  - WRITE: o_ready=0, o_mem_we=1, exactly one cycle.
  - DONE: o_ready=0; holds until i_clear or reset.
- Handshake: a pair is accepted on the rising edge where i_valid && o_ready. No accept occurs outside IDLE. Inputs are ignored when not accepted.
- Range rule:
  - Operand is in range iff i_operand[N_BUS-1:N_BUS_IN]==0, matching the zero extension performed on decode.
  - No saturation and no sign interpretation.
  - Range is checked at the accept edge.
- Accept, in range:
  - Register o_mem_data={i_opcode, i_operand[N_BUS_IN-1:0]} and go to WRITE.
  - o_mem_addr is the current write pointer.
  - Latency: accept at edge k, o_mem_we high during cycle k+1, o_ready high again from cycle k+2 (one word per 2 cycles maximum).
- Accept, out of range:
  - No write, pointer unchanged, stay in IDLE.
  - o_err set from the next cycle and held until i_clear or reset.
- Leaving WRITE (next edge):
  - o_count increments and the address pointer increments.
  - If the written opcode == HALT_OP: o_done=1, go to DONE.
  - Else if the written address == 2**N_ADDR-1: o_full=1, go to DONE (no wrap-around).
  - Else return to IDLE.
  - HALT written at the last address sets only o_done.
- o_mem_addr holds the last address written after a write; o_mem_data holds the last packed word.
- i_clear:
  - Highest synchronous priority: beats i_valid and a pending WRITE.
  - If asserted during WRITE, the strobe already driven that cycle completes, but the pointer and count are reset, not incremented.
  - Next cycle: IDLE, o_mem_addr=0, o_count=0, all flags 0.
- Purely synchronous except reset. No combinational path from i_valid to o_mem_we.

Test Plan:
- Reset then send (op=5'b00001, operand=16'h0005) -> cycle k+1: o_mem_we=1, addr 0, data 16'h0805; then o_count=1, o_ready=1.
- Send operand 16'h07FF (max) with op 5'b00011 -> data 16'h1FFF written. Send operand 16'h0800 -> no write, o_err=1 sticky, o_count unchanged, next valid pair writes at the unchanged address.
- Load 3 words then op=HALT_OP operand 0 -> data 16'h0000 written at addr 3, o_done=1, o_ready=0; further i_valid ignored (no o_mem_we).
- N_ADDR=3: stream 8 non-HALT words with i_valid held high -> o_mem_we every other cycle, addresses 0..7, o_full=1 after address 7, count=8, no ninth write.
- Assert i_clear together with i_valid in IDLE -> no accept; next cycle address 0, flags cleared. Assert i_clear during WRITE -> pointer returns to 0.
- Assert i_reset asynchronously mid-WRITE -> o_mem_we falls before the next clock edge; all outputs at reset values; first subsequent word goes to address 0.

Source files
------------

// File: rtl/instr_packer_if.sv
// Loader-to-packer bundle: opcode/operand handshake in, program memory write port
// and load status out.
interface instr_packer_if #(
   parameter int N_BUS    = 16,
   parameter int N_BUS_IN = 11,
   parameter int N_ADDR   = 11
);
   logic                       i_clear;
   logic                       i_valid;
   logic [N_BUS-N_BUS_IN-1:0]  i_opcode;
   logic [N_BUS-1:0]           i_operand;
   logic                       o_ready;
   logic                       o_mem_we;
   logic [N_ADDR-1:0]          o_mem_addr;
   logic [N_BUS-1:0]           o_mem_data;
   logic [N_ADDR:0]            o_count;
   logic                       o_err;
   logic                       o_done;
   logic                       o_full;

   modport master (
      output i_clear, i_valid, i_opcode, i_operand,
      input  o_ready, o_mem_we, o_mem_addr, o_mem_data,
      input  o_count, o_err, o_done, o_full
   );

   modport slave (
      input  i_clear, i_valid, i_opcode, i_operand,
      output o_ready, o_mem_we, o_mem_addr, o_mem_data,
      output o_count, o_err, o_done, o_full
   );
endinterface

// File: rtl/instr_packer.sv
// Narrows operands to the instruction field, packs them with an opcode and
// writes the resulting words sequentially into program memory.
module instr_packer #(
   parameter int N_BUS    = 16,
   parameter int N_BUS_IN = 11,
   parameter int N_ADDR   = 11,
   parameter logic [N_BUS-N_BUS_IN-1:0] HALT_OP = '0
) (
   input  logic          i_clk,
   input  logic          i_reset,
   instr_packer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } state_t;

   localparam logic [N_ADDR-1:0] LAST = '1;
   localparam logic [N_ADDR:0]   ONE  = (N_ADDR+1)'(1);

   state_t              state, state_n;
   logic [N_ADDR-1:0]   addr, addr_n;
   logic [N_BUS-1:0]    data, data_n;
   logic [N_ADDR:0]     count, count_n;
   logic                err, err_n;
   logic                done, done_n;
   logic                full, full_n;
   logic                in_range;

   // Upper bits must be zero so the core's zero extension restores the value
   assign in_range = (bus.i_operand[N_BUS-1:N_BUS_IN] == '0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
         addr  <= '0;
         data  <= '0;
         count <= '0;
         err   <= 1'b0;
         done  <= 1'b0;
         full  <= 1'b0;
      end else begin
         state <= state_n;
         addr  <= addr_n;
         data  <= data_n;
         count <= count_n;
         err   <= err_n;
         done  <= done_n;
         full  <= full_n;
      end
   end

   always_comb begin
      state_n = state;
      addr_n  = addr;
      data_n  = data;
      count_n = count;
      err_n   = err;
      done_n  = done;
      full_n  = full;
      if (bus.i_clear) begin
         state_n = IDLE;
         addr_n  = '0;
         count_n = '0;
         err_n   = 1'b0;
         done_n  = 1'b0;
         full_n  = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  if (in_range) begin
                     data_n  = {bus.i_opcode,
                                bus.i_operand[N_BUS_IN-1:0]};
                     addr_n  = count[N_ADDR-1:0];
                     state_n = WRITE;
                  end else begin
                     err_n = 1'b1;
                  end
               end
            end
            WRITE: begin
               // count doubles as the write pointer
               count_n = count + ONE;
               if (data[N_BUS-1:N_BUS_IN] == HALT_OP) begin
                  done_n  = 1'b1;
                  state_n = DONE;
               end else if (addr == LAST) begin
                  full_n  = 1'b1;
                  state_n = DONE;
               end else begin
                  state_n = IDLE;
               end
            end
            DONE: begin
               state_n = DONE;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   assign bus.o_ready    = (state == IDLE);
   assign bus.o_mem_we   = (state == WRITE);
   assign bus.o_mem_addr = addr;
   assign bus.o_mem_data = data;
   assign bus.o_count    = count;
   assign bus.o_err      = err;
   assign bus.o_done     = done;
   assign bus.o_full     = full;

endmodule

// File: tb/tb_instr_packer.sv
// Directed and randomized checks of instr_packer against a transaction-level
// model of the load sequence (small memory: N_ADDR=3).
module tb_instr_packer;

   localparam int NB    = 16;
   localparam int NI    = 11;
   localparam int NA    = 3;
   localparam int DEPTH = 1 << NA;
   localparam logic [4:0] HALT = 5'b00000;

   logic i_clk   = 1'b0;
   logic i_reset = 1'b1;

   instr_packer_if #(.N_BUS(NB), .N_BUS_IN(NI), .N_ADDR(NA)) bus ();

   instr_packer #(
      .N_BUS(NB), .N_BUS_IN(NI), .N_ADDR(NA), .HALT_OP(HALT)
   ) dut (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .bus    (bus.slave)
   );

   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;
   bit exp_err = 0;
   bit exp_done = 0;
   bit exp_full = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_cnt  = 0;
      exp_err  = 0;
      exp_done = 0;
      exp_full = 0;
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, ".we"},    bus.o_mem_we, 0);
      chk({tag, ".ready"}, bus.o_ready, !(exp_done || exp_full));
      chk({tag, ".count"}, bus.o_count, exp_cnt);
      chk({tag, ".err"},   bus.o_err, exp_err);
      chk({tag, ".done"},  bus.o_done, exp_done);
      chk({tag, ".full"},  bus.o_full, exp_full);
   endtask

   function automatic logic [15:0] pack(input logic [4:0] op,
                                        input logic [15:0] opd);
      return 16'(int'(op) * 2048 + int'(opd));
   endfunction

   // One pair presented for one cycle while the packer is idle
   task automatic send(input logic [4:0] op, input logic [15:0] opd);
      logic [15:0] word;
      bus.i_valid   = 1'b1;
      bus.i_opcode  = op;
      bus.i_operand = opd;
      @(negedge i_clk);
      bus.i_valid = 1'b0;
      if (opd < 16'd2048) begin
         word = pack(op, opd);
         chk("send.we",    bus.o_mem_we, 1);
         chk("send.rdy",   bus.o_ready, 0);
         chk("send.addr",  bus.o_mem_addr, exp_cnt);
         chk("send.data",  bus.o_mem_data, word);
         @(negedge i_clk);
         exp_cnt++;
         if (op == HALT) exp_done = 1;
         else if (exp_cnt == DEPTH) exp_full = 1;
         chk("send.ahold", bus.o_mem_addr, exp_cnt - 1);
         chk("send.dhold", bus.o_mem_data, word);
      end else begin
         exp_err = 1;
      end
      chk_flags("send");
   endtask

   task automatic do_clear();
      bus.i_clear = 1'b1;
      @(negedge i_clk);
      bus.i_clear = 1'b0;
      model_clear();
      chk("clr.addr", bus.o_mem_addr, 0);
      chk_flags("clr");
   endtask

   initial begin
      logic [15:0] word;
      int guard;
      bus.i_clear   = 1'b0;
      bus.i_valid   = 1'b0;
      bus.i_opcode  = '0;
      bus.i_operand = '0;

      repeat (2) @(negedge i_clk);
      chk("rst.addr", bus.o_mem_addr, 0);
      chk("rst.data", bus.o_mem_data, 0);
      chk_flags("rst");
      i_reset = 1'b0;
      @(negedge i_clk);
      chk_flags("idle");

      send(5'b00001, 16'h0005);
      send(5'b00011, 16'h07FF);
      send(5'b00010, 16'h0800);
      send(5'b00100, 16'h0123);
      send(HALT, 16'h0000);

      bus.i_valid   = 1'b1;
      bus.i_opcode  = 5'd5;
      bus.i_operand = 16'h0001;
      repeat (4) begin
         @(negedge i_clk);
         chk("done.we", bus.o_mem_we, 0);
         chk("done.cnt", bus.o_count, exp_cnt);
      end
      bus.i_valid = 1'b0;
      chk_flags("done");

      do_clear();

      send(5'd7, 16'hFFFF);
      bus.i_valid   = 1'b1;
      bus.i_opcode  = 5'd6;
      bus.i_operand = 16'h0010;
      bus.i_clear   = 1'b1;
      @(negedge i_clk);
      bus.i_valid = 1'b0;
      bus.i_clear = 1'b0;
      model_clear();
      chk("clrv.addr", bus.o_mem_addr, 0);
      chk_flags("clrv");
      @(negedge i_clk);
      chk("clrv.we2", bus.o_mem_we, 0);

      send(5'd9, 16'h0042);
      bus.i_valid   = 1'b1;
      bus.i_opcode  = 5'd10;
      bus.i_operand = 16'h0077;
      @(negedge i_clk);
      bus.i_valid = 1'b0;
      chk("clrw.we", bus.o_mem_we, 1);
      chk("clrw.addr", bus.o_mem_addr, 1);
      do_clear();
      send(5'd11, 16'h0033);

      do_clear();
      bus.i_valid   = 1'b1;
      bus.i_opcode  = 5'($urandom_range(1, 31));
      bus.i_operand = 16'($urandom_range(0, 2047));
      for (int i = 0; i < DEPTH; i++) begin
         word = pack(bus.i_opcode, bus.i_operand);
         @(negedge i_clk);
         chk("strm.we", bus.o_mem_we, 1);
         chk("strm.addr", bus.o_mem_addr, i);
         chk("strm.data", bus.o_mem_data, word);
         bus.i_opcode  = 5'($urandom_range(1, 31));
         bus.i_operand = 16'($urandom_range(0, 2047));
         @(negedge i_clk);
         exp_cnt++;
         if (exp_cnt == DEPTH) exp_full = 1;
         chk_flags("strm");
      end
      repeat (4) begin
         @(negedge i_clk);
         chk("full.we", bus.o_mem_we, 0);
      end
      bus.i_valid = 1'b0;
      chk_flags("full");

      do_clear();
      guard = 0;
      while (exp_cnt < DEPTH - 1 && guard < 200) begin
         guard++;
         if ($urandom_range(0, 3) == 0)
            send(5'($urandom_range(1, 31)), 16'($urandom));
         else
            send(5'($urandom_range(1, 31)),
                 16'($urandom_range(0, 2047)));
      end
      send(HALT, 16'($urandom_range(0, 2047)));

      do_clear();
      send(5'd12, 16'h0100);
      bus.i_valid   = 1'b1;
      bus.i_opcode  = 5'd13;
      bus.i_operand = 16'h0200;
      @(posedge i_clk);
      #1;
      bus.i_valid = 1'b0;
      chk("arst.we_pre", bus.o_mem_we, 1);
      #2;
      i_reset = 1'b1;
      #1;
      model_clear();
      chk("arst.addr", bus.o_mem_addr, 0);
      chk("arst.data", bus.o_mem_data, 0);
      chk_flags("arst");
      @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      send(5'd14, 16'h0321);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
